// File: rtl/nco_tuner_if.sv
// nco_tuner_if: raw tuning buttons in, NCO phase increment and status out.
// btn_preset exists only when NCO_TUNER_PRESET_EN is defined.
interface nco_tuner_if #(parameter int PHASE_W = 40);
  logic btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn;
  logic [PHASE_W-1:0] phase_inc;
  logic step_tick, at_limit;
`ifdef NCO_TUNER_PRESET_EN
  logic btn_preset;
  modport master (output btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn, btn_preset,
                  input phase_inc, step_tick, at_limit);
  modport slave (input btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn, btn_preset,
                 output phase_inc, step_tick, at_limit);
`else
  modport master (output btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn,
                  input phase_inc, step_tick, at_limit);
  modport slave (input btn_fine_up, btn_fine_dn, btn_coarse_up, btn_coarse_dn,
                 output phase_inc, step_tick, at_limit);
`endif
endinterface

// File: rtl/nco_tuner.sv
// nco_tuner: debounced button stepping of the NCO phase increment with auto-repeat and band saturation.
// Defining NCO_TUNER_PRESET_EN adds btn_preset cycling through an 8-entry station preset ROM.
module nco_tuner #(
  parameter int PHASE_W = 40,
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE = 10000000,
  parameter logic [PHASE_W-1:0] FINE_STEP = 40'h110c6f7,
  parameter logic [PHASE_W-1:0] COARSE_STEP = 40'h1346dc5d,
  parameter logic [PHASE_W-1:0] PHASE_MIN = 40'h17f62b6ae,
  parameter logic [PHASE_W-1:0] PHASE_MAX = 40'h47ae147ae1,
  parameter logic [PHASE_W-1:0] PHASE_RESET = 40'h2656abde3
) (
  input logic CLK,
  input logic RST,
  nco_tuner_if.slave io
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
`ifdef NCO_TUNER_PRESET_EN
  localparam int NB = 5;
  localparam logic [PHASE_W-1:0] ROM [8] = '{40'h17f62b6ae, 40'h1e98dcdb3, 40'h25edd0529, 40'h2656abde3,
                                             40'h41fc8f323, 40'h42b94d940, 40'h11eb851eb8, 40'h23d70a3d70};
  logic [2:0] idx_q, idx_d;
`else
  localparam int NB = 4;
`endif
  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;
  typedef enum logic [2:0] {NONE, FINE_UP, FINE_DN, CRS_UP, CRS_DN} cmd_t;
  logic [NB-1:0] raw, s1_q, s2_q, deb_q, deb_d;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];
  state_t state_q, state_d;
  cmd_t cmd, last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PHASE_W-1:0] phase_q, phase_d, amt, stepped;
  logic [PHASE_W:0] sum, diff;
  logic step, up, tick_q, tick_d, lim_q, lim_d;
`ifdef NCO_TUNER_PRESET_EN
  assign raw = {io.btn_preset, io.btn_coarse_dn, io.btn_coarse_up, io.btn_fine_dn, io.btn_fine_up};
`else
  assign raw = {io.btn_coarse_dn, io.btn_coarse_up, io.btn_fine_dn, io.btn_fine_up};
`endif
  // a level is accepted only after DEBOUNCE_CYC straight cycles of disagreement with the current one
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = (s2_q[i] == deb_q[i]) ? '0 : cnt_q[i] + 1'b1;
      if (s2_q[i] != deb_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end
    end
  end
  always_comb
    cmd = (deb_q[2] | deb_q[3]) ? ((deb_q[2] ^ deb_q[3]) ? (deb_q[2] ? CRS_UP : CRS_DN) : NONE)
                                : ((deb_q[0] ^ deb_q[1]) ? (deb_q[0] ? FINE_UP : FINE_DN) : NONE);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d = last_q;
    step = 1'b0;
    case (state_q)
      IDLE: if (cmd != NONE) begin
        state_d = FIRST;
        last_d = cmd;
      end
      FIRST: begin
        step = 1'b1;
        timer_d = TW'(REPEAT_DELAY);
        state_d = HOLD;
      end
      default: if (cmd == NONE) state_d = IDLE;
      else if (cmd != last_q) begin
        state_d = FIRST;
        last_d = cmd;
      end else if (timer_q <= TW'(1)) begin
        step = 1'b1;
        timer_d = TW'(REPEAT_RATE);
        state_d = REPEAT;
      end else timer_d = timer_q - 1'b1;
    endcase
  end
  // one extra bit keeps overflow and underflow visible so the limits clamp instead of wrapping
  assign up = last_q == FINE_UP || last_q == CRS_UP;
  assign amt = (last_q == CRS_UP || last_q == CRS_DN) ? COARSE_STEP : FINE_STEP;
  assign sum = {1'b0, phase_q} + {1'b0, amt};
  assign diff = {1'b0, phase_q} - {1'b0, amt};
  assign stepped = up ? ((sum > {1'b0, PHASE_MAX}) ? PHASE_MAX : sum[PHASE_W-1:0])
                      : ((diff[PHASE_W] || diff[PHASE_W-1:0] < PHASE_MIN) ? PHASE_MIN : diff[PHASE_W-1:0]);
  always_comb begin
    phase_d = step ? stepped : phase_q;
    tick_d = step && stepped != phase_q;
`ifdef NCO_TUNER_PRESET_EN
    idx_d = idx_q;
    if (deb_d[4] && !deb_q[4]) begin
      idx_d = idx_q + 1'b1;
      phase_d = ROM[idx_d];
      tick_d = 1'b1;
    end
`endif
    lim_d = phase_d == PHASE_MIN || phase_d == PHASE_MAX;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      last_q <= NONE;
      timer_q <= '0;
      phase_q <= PHASE_RESET;
      tick_q <= 1'b0;
      lim_q <= 1'b0;
`ifdef NCO_TUNER_PRESET_EN
      idx_q <= 3'd3;
`endif
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      last_q <= last_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      tick_q <= tick_d;
      lim_q <= lim_d;
`ifdef NCO_TUNER_PRESET_EN
      idx_q <= idx_d;
`endif
    end
  assign io.phase_inc = phase_q;
  assign io.step_tick = tick_q;
  assign io.at_limit = lim_q;
endmodule

// File: tb/tb_nco_tuner.sv
// tb_nco_tuner: directed stimulus with a queue of expected phase values popped on every step_tick.
module tb_nco_tuner;
  localparam logic [39:0] FINE = 40'h110c6f7;
  localparam logic [39:0] COARSE = 40'h1346dc5d;
  localparam logic [39:0] PMIN = 40'h17f62b6ae;
  localparam logic [39:0] PMAX = 40'h47ae147ae1;
  localparam logic [39:0] PRST = 40'h2656abde3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, ticks = 0, t_exp = 0;
  logic [39:0] exp_q[$];
  int tick_cyc[$];
  logic [39:0] exp_phase;
  nco_tuner_if #(.PHASE_W(40)) io();
  nco_tuner #(.DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (.CLK(clk), .RST(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst && io.step_tick === 1'b1) begin
      ticks++;
      tick_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("tick_without_expect", 64'(io.step_tick), 64'd0);
      else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("phase_on_tick", 64'(io.phase_inc), 64'(e));
        chk("at_limit_on_tick", 64'(io.at_limit), 64'(e == PMIN || e == PMAX));
      end
    end
  end
  function automatic logic [39:0] m_up(input logic [39:0] p, input logic [39:0] s);
    logic [40:0] t;
    t = {1'b0, p} + {1'b0, s};
    return (t > {1'b0, PMAX}) ? PMAX : t[39:0];
  endfunction
  function automatic logic [39:0] m_dn(input logic [39:0] p, input logic [39:0] s);
    return (p < s || p - s < PMIN) ? PMIN : p - s;
  endfunction
  task automatic push(input logic [39:0] v);
    exp_phase = v;
    exp_q.push_back(v);
    t_exp++;
  endtask
  task automatic btn(input logic fu, input logic fd, input logic cu, input logic cd);
    io.btn_fine_up = fu;
    io.btn_fine_dn = fd;
    io.btn_coarse_up = cu;
    io.btn_coarse_dn = cd;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int b;
`ifdef NCO_TUNER_PRESET_EN
    logic [39:0] rom [8];
    int idx;
    rom = '{40'h17f62b6ae, 40'h1e98dcdb3, 40'h25edd0529, 40'h2656abde3,
            40'h41fc8f323, 40'h42b94d940, 40'h11eb851eb8, 40'h23d70a3d70};
    io.btn_preset = 1'b0;
`endif
    btn(0, 0, 0, 0);
    idle(3);
    chk("reset_phase", 64'(io.phase_inc), 64'h2656abde3);
    chk("reset_tick", 64'(io.step_tick), 64'd0);
    chk("reset_limit", 64'(io.at_limit), 64'd0);
    rst = 1'b0;
    exp_phase = PRST;
    idle(2);
    btn(1, 0, 0, 0);
    idle(3);
    btn(0, 0, 0, 0);
    idle(15);
    chk("glitch_ticks", 64'(ticks), 64'd0);
    chk("glitch_phase", 64'(io.phase_inc), 64'(PRST));
    push(m_up(exp_phase, FINE));
    btn(1, 0, 0, 0);
    idle(10);
    btn(0, 0, 0, 0);
    drain("fine_press_drain", 30);
    idle(30);
    chk("fine_press_ticks", 64'(ticks), 64'd1);
    chk("fine_press_phase", 64'(io.phase_inc), 64'h2667b84da);
    b = tick_cyc.size();
    for (int i = 0; i < 9; i++) push(m_dn(exp_phase, COARSE));
    btn(0, 0, 0, 1);
    drain("coarse_hold_drain", 200);
    push(m_dn(exp_phase, COARSE));
    btn(0, 0, 0, 0);
    drain("coarse_release_drain", 30);
    idle(40);
    chk("coarse_hold_ticks", 64'(ticks), 64'(t_exp));
    chk("hold_delay", 64'(tick_cyc[b+1] - tick_cyc[b]), 64'd20);
    chk("repeat_rate", 64'(tick_cyc[b+2] - tick_cyc[b+1]), 64'd5);
    chk("repeat_rate_last", 64'(tick_cyc[b+9] - tick_cyc[b+8]), 64'd5);
    push(m_up(exp_phase, COARSE));
    btn(1, 0, 1, 0);
    idle(10);
    btn(0, 0, 0, 0);
    drain("coarse_wins_drain", 30);
    idle(30);
    btn(1, 1, 0, 0);
    idle(30);
    btn(0, 0, 1, 1);
    idle(30);
    btn(0, 0, 0, 0);
    idle(20);
    chk("opposed_ticks", 64'(ticks), 64'(t_exp));
    chk("opposed_phase", 64'(io.phase_inc), 64'(exp_phase));
    while (exp_phase != PMAX) push(m_up(exp_phase, COARSE));
    btn(0, 0, 1, 0);
    drain("saturate_drain", 6000);
    idle(40);
    chk("saturate_phase", 64'(io.phase_inc), 64'h47ae147ae1);
    chk("saturate_limit", 64'(io.at_limit), 64'd1);
    chk("saturate_ticks", 64'(ticks), 64'(t_exp));
    btn(0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 3; i++) push(m_dn(exp_phase, FINE));
    btn(0, 1, 0, 0);
    drain("repeat_before_rst", 100);
    chk("left_limit", 64'(io.at_limit), 64'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_phase", 64'(io.phase_inc), 64'(PRST));
    chk("async_rst_tick", 64'(io.step_tick), 64'd0);
    chk("async_rst_limit", 64'(io.at_limit), 64'd0);
    idle(3);
    exp_phase = PRST;
    push(m_dn(exp_phase, FINE));
    rst = 1'b0;
    drain("held_after_rst", 40);
    btn(0, 0, 0, 0);
    idle(30);
    chk("held_after_rst_ticks", 64'(ticks), 64'(t_exp));
`ifdef NCO_TUNER_PRESET_EN
    idx = 3;
    for (int i = 0; i < 9; i++) begin
      idx = (idx + 1) % 8;
      push(rom[idx]);
      io.btn_preset = 1'b1;
      idle(10);
      io.btn_preset = 1'b0;
      idle(10);
    end
    drain("preset_drain", 20);
    chk("preset_wrap_phase", 64'(io.phase_inc), 64'h41fc8f323);
    chk("preset_ticks", 64'(ticks), 64'(t_exp));
`endif
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
